// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: default widths, vectors and FSM encoding.
package fetch_sequencer_pkg;

    localparam int unsigned DEF_PC_W  = 32;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic [DEF_PC_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [DEF_PC_W-1:0] DEF_TRAP_VECTOR  = 32'h0000_0010;

    // Encoding is visible on the debug STATE port, so values are fixed.
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StStalled  = 2'd1,
        StRedirect = 2'd2,
        StHalted   = 2'd3
    } state_e;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module fetch_sequencer_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; clear has priority, stop at the maximum value.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer for the IF stage: increment, stall hold, branch redirect
// with flush, trap vectoring with saved return PC, and halt/resume.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned        PC_W         = DEF_PC_W,
    parameter logic [PC_W-1:0]    RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [PC_W-1:0]    TRAP_VECTOR  = DEF_TRAP_VECTOR,
    parameter int unsigned        CNT_W        = DEF_CNT_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [PC_W-1:0]  i_br_target,
    input  logic             i_trap,
    input  logic             i_halt,
    input  logic             i_resume,
    output logic [PC_W-1:0]  o_pc,
    output logic [PC_W-1:0]  o_pc_m1,
    output logic             o_fetch_valid,
    output logic             o_flush,
    output logic [PC_W-1:0]  o_epc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [1:0]       o_state
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_epc;
    logic            r_fetch_valid;
    logic            r_flush;

    logic [PC_W-1:0] w_pc_inc;
    logic            w_stall_en;

    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // Counter advances on every edge that lands in (or stays in) STALLED.
    assign w_stall_en = !i_trap && (r_state != StHalted) && !i_br_taken && !i_halt && i_stall;

    // Sequencer FSM: priority RESET > TRAP > (HALTED handling) > BR_TAKEN > HALT > STALL > increment.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc          <= RESET_VECTOR;
            r_state       <= StRun;
            r_fetch_valid <= 1'b0;  // first fetch after reset is not yet valid
            r_flush       <= 1'b0;
            r_epc         <= '0;
        end else if (i_trap) begin
            // A branch resolving on the same edge is the architectural return point.
            r_epc         <= i_br_taken ? i_br_target : r_pc;
            r_pc          <= TRAP_VECTOR;
            r_state       <= StRedirect;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b1;
        end else if (r_state == StHalted) begin
            // STALL and BR_TAKEN are ignored; RESUME beats HALT.
            r_flush <= 1'b0;
            if (i_resume) begin
                r_pc          <= w_pc_inc;
                r_state       <= StRun;
                r_fetch_valid <= 1'b1;
            end else begin
                r_fetch_valid <= 1'b0;
            end
        end else if (i_br_taken) begin
            // Overrides STALL: EX is downstream of the stalled IF/ID register.
            r_pc          <= i_br_target;
            r_state       <= StRedirect;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b1;
        end else if (i_halt) begin
            r_state       <= StHalted;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
        end else if (i_stall) begin
            r_state       <= StStalled;
            r_fetch_valid <= 1'b1;  // held instruction stays valid
            r_flush       <= 1'b0;
        end else begin
            r_pc          <= w_pc_inc;
            r_state       <= StRun;
            r_fetch_valid <= 1'b1;
            r_flush       <= 1'b0;
        end
    end

    fetch_sequencer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clock  (i_clock),
        .i_clear  (i_reset),
        .i_enable (w_stall_en),
        .o_count  (o_stall_cnt)
    );

    assign o_pc          = r_pc;
    assign o_pc_m1       = w_pc_inc;
    assign o_fetch_valid = r_fetch_valid;
    assign o_flush       = r_flush;
    assign o_epc         = r_epc;
    assign o_state       = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vectors, a behavioural model
// checked every cycle, and literal expectations pinning the scenarios.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br, trap, halt, resume;
    logic [31:0] tgt;

    logic [31:0] o_pc, o_pc_m1, o_epc;
    logic        o_fetch_valid, o_flush;
    logic [15:0] o_stall_cnt;
    logic [1:0]  o_state;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state (states: 0 run, 1 stalled, 2 redirect, 3 halted).
    logic [31:0] m_pc, m_epc;
    int          m_st, m_cnt;
    logic        m_fv, m_fl;
    bit          m_live = 1'b0;

    fetch_sequencer u_dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_stall       (stall),
        .i_br_taken    (br),
        .i_br_target   (tgt),
        .i_trap        (trap),
        .i_halt        (halt),
        .i_resume      (resume),
        .o_pc          (o_pc),
        .o_pc_m1       (o_pc_m1),
        .o_fetch_valid (o_fetch_valid),
        .o_flush       (o_flush),
        .o_epc         (o_epc),
        .o_stall_cnt   (o_stall_cnt),
        .o_state       (o_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model on the edge.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic tr, input logic h, input logic rs);
        rst = r; stall = s; br = b; tgt = t; trap = tr; halt = h; resume = rs;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_st = 0; m_fv = 1'b0; m_fl = 1'b0; m_epc = 32'h0; m_cnt = 0;
            m_live = 1'b1;
        end else begin
            if (tr) begin
                m_epc = b ? t : m_pc;
                m_pc  = 32'h10;
                m_st  = 2;
            end else if (m_st == 3) begin
                if (rs) begin
                    m_pc = m_pc + 32'd1;
                    m_st = 0;
                end
            end else if (b) begin
                m_pc = t;
                m_st = 2;
            end else if (h) begin
                m_st = 3;
            end else if (s) begin
                m_st = 1;
            end else begin
                m_pc = m_pc + 32'd1;
                m_st = 0;
            end
            if (m_st == 1 && m_cnt < 65535) m_cnt++;
            m_fv = (m_st == 0) || (m_st == 1);
            m_fl = (m_st == 2);
        end
        #1;
    endtask

    task automatic run();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset1();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("pc", o_pc, m_pc);
            chk("pc_m1", o_pc_m1, m_pc + 32'd1);
            chk1("fetch_valid", o_fetch_valid, m_fv);
            chk1("flush", o_flush, m_fl);
            chk("epc", o_epc, m_epc);
            chk("stall_cnt", 32'(o_stall_cnt), 32'(m_cnt));
            chk("state", 32'(o_state), 32'(m_st));
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0; trap = 1'b0; halt = 1'b0;
        resume = 1'b0;

        // 1: reset two cycles, then sequential fetch
        reset1();
        reset1();
        chk("t1_reset_pc", o_pc, 32'h0);
        chk1("t1_reset_fv", o_fetch_valid, 1'b0);
        chk1("t1_reset_flush", o_flush, 1'b0);
        chk("t1_reset_epc", o_epc, 32'h0);
        chk("t1_reset_cnt", 32'(o_stall_cnt), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            run();
            chk("t1_pc", o_pc, 32'(i));
            chk("t1_pc_m1", o_pc_m1, 32'(i + 1));
            chk1("t1_fv", o_fetch_valid, 1'b1);
        end

        // 2: stall three cycles at PC=3
        reset1();
        run(); run(); run();
        chk("t2_pc_pre", o_pc, 32'h3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk("t2_pc_hold", o_pc, 32'h3);
        end
        chk("t2_state", 32'(o_state), 32'h1);
        chk("t2_cnt", 32'(o_stall_cnt), 32'h3);
        chk1("t2_fv", o_fetch_valid, 1'b1);
        run();
        chk("t2_pc_rel", o_pc, 32'h4);
        chk("t2_state_rel", 32'(o_state), 32'h0);

        // 3: branch at PC=7 to 0x40, then back-to-back redirects and stall in redirect
        run(); run(); run();
        chk("t3_pc_pre", o_pc, 32'h7);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        chk("t3_pc_tgt", o_pc, 32'h40);
        chk1("t3_flush", o_flush, 1'b1);
        chk1("t3_fv", o_fetch_valid, 1'b0);
        run();
        chk("t3_pc_next", o_pc, 32'h41);
        chk1("t3_flush_off", o_flush, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        chk("t3_rebr_pc", o_pc, 32'h30);
        chk1("t3_rebr_flush", o_flush, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3_redir_stall_pc", o_pc, 32'h30);
        chk("t3_redir_stall_st", 32'(o_state), 32'h1);
        run();
        chk("t3_after_pc", o_pc, 32'h31);

        // 4: trap and branch on the same edge at PC=9
        reset1();
        for (int i = 0; i < 9; i++) run();
        chk("t4_pc_pre", o_pc, 32'h9);
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        chk("t4_epc", o_epc, 32'h80);
        chk("t4_pc", o_pc, 32'h10);
        chk1("t4_flush", o_flush, 1'b1);
        run();
        chk("t4_pc_next", o_pc, 32'h11);
        chk1("t4_flush_off", o_flush, 1'b0);

        // 5: halt at PC=5, noise ignored, resume beats halt, trap wakes halted
        reset1();
        for (int i = 0; i < 5; i++) run();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t5_halt_pc", o_pc, 32'h5);
        chk("t5_halt_st", 32'(o_state), 32'h3);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
        chk("t5_hold_pc", o_pc, 32'h5);
        chk1("t5_hold_fv", o_fetch_valid, 1'b0);
        chk1("t5_hold_flush", o_flush, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("t5_resume_pc", o_pc, 32'h6);
        chk("t5_resume_st", 32'(o_state), 32'h0);
        chk1("t5_resume_fv", o_fetch_valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_wake_pc", o_pc, 32'h10);
        chk("t5_wake_epc", o_epc, 32'h6);

        // 6: wrap at all-ones, then reset during STALLED
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("t6_pc_max", o_pc, 32'hFFFF_FFFF);
        chk("t6_pc_m1_wrap", o_pc_m1, 32'h0);
        run();
        chk("t6_pc_wrap", o_pc, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_cnt_pre", 32'(o_stall_cnt), 32'h2);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_pc", o_pc, 32'h0);
        chk("t6_rst_cnt", 32'(o_stall_cnt), 32'h0);
        chk("t6_rst_st", 32'(o_state), 32'h0);
        run();
        chk("t6_post_pc", o_pc, 32'h1);
        chk1("t6_post_fv", o_fetch_valid, 1'b1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
